xmem_unaligned_seq: RTL

Request sequencer that sits directly upstream of the byte-addressed single-port xmem bank and drives its port (we, len, adr, din) and consumes its read data.
- Accepts one byte/halfword/word access per valid/ready handshake.
- Issues naturally aligned accesses unchanged.
- Splits misaligned halfword/word accesses into sequential byte beats, because the bank can only handle accesses contained in one aligned 32-bit word.
- Reassembles read bytes and returns one response per request.

---
 rtl/xmem_unaligned_seq_if.sv | 41 ++++
 rtl/xmem_unaligned_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xmem_unaligned_seq_if.sv
// Request/response and bank-port bundle for the xmem unaligned-access sequencer.
// The slave view belongs to the sequencer. The master view belongs to its environment,
// which is the upstream requester together with the xmem bank.
interface xmem_unaligned_seq_if #(
  parameter int XMEM_AW = 12
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_len;
  logic [XMEM_AW-1:0] req_adr;
  logic [31:0]        req_din;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_rdata;

  logic               bank_we;
  logic [1:0]         bank_len;
  logic [XMEM_AW-1:0] bank_adr;
  logic [31:0]        bank_din;
  logic [31:0]        bank_dout;

  modport slave (
    input  req_valid, req_we, req_len, req_adr, req_din,
    output req_ready,
    output rsp_valid, rsp_rdata,
    input  rsp_ready,
    output bank_we, bank_len, bank_adr, bank_din,
    input  bank_dout
  );

  modport master (
    output req_valid, req_we, req_len, req_adr, req_din,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    output rsp_ready,
    input  bank_we, bank_len, bank_adr, bank_din,
    output bank_dout
  );
endinterface

// File: rtl/xmem_unaligned_seq.sv
// Request sequencer in front of the byte-addressed single-port xmem bank.
// Naturally aligned accesses go to the bank as one beat. Misaligned halfword and word
// accesses are split into byte beats, because the bank only handles accesses that fit
// inside one aligned 32-bit word. Read bytes are reassembled into a single response.
// Only one request is outstanding at a time.
module xmem_unaligned_seq #(
  parameter int AW       = 10,
  parameter bit SPLIT_EN = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  xmem_unaligned_seq_if.slave bus
);

  // The bank has AW word-address bits, so the byte address space is AW+2 bits wide.
  localparam int XMEM_AW = AW + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // A halfword is misaligned when it is on an odd address. A word is misaligned when
  // its address is not a multiple of 4. Bytes, including len=2, are never misaligned.
  function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
    logic mis;
    case (len)
      2'd1:    mis = off[0];
      2'd3:    mis = (off != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Index of the final byte beat of a split access.
  function automatic logic [1:0] last_beat_of(input logic [1:0] len);
    return (len == 2'd3) ? 2'd3 : 2'd1;
  endfunction

  // The bank right-justifies its read data. Keep only the bytes that were requested.
  function automatic logic [31:0] mask_read(input logic [1:0] len, input logic [31:0] dout);
    logic [31:0] res;
    case (len)
      2'd1:    res = {16'h0000, dout[15:0]};
      2'd3:    res = dout;
      default: res = {24'h000000, dout[7:0]};
    endcase
    return res;
  endfunction

  // Select byte k of a little-endian word.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Captured copy of the accepted request. The req_* inputs are ignored once the request is accepted.
  logic               cap_we;
  logic [1:0]         cap_len;
  logic [XMEM_AW-1:0] cap_adr;
  logic [31:0]        cap_din;

  // Beat sequencing control.
  logic       split;
  logic [1:0] last;
  logic [1:0] beat;
  logic [1:0] beat_nxt;
  logic [1:0] beat_inc;

  // Read bytes of beats 0..2. The byte of the final beat comes straight from bank_dout.
  logic [2:0][7:0] rbuf;

  // Registered bank port, plus the values it loads at the next edge.
  logic               port_we;
  logic [1:0]         port_len;
  logic [XMEM_AW-1:0] port_adr;
  logic [31:0]        port_din;
  logic               port_we_nxt;
  logic [1:0]         port_len_nxt;
  logic [XMEM_AW-1:0] port_adr_nxt;
  logic [31:0]        port_din_nxt;

  // Response register.
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] resp_data_nxt;

  logic ready;
  logic accept;
  logic split_now;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign split_now = SPLIT_EN && is_misaligned(bus.req_len, bus.req_adr[1:0]);
  assign beat_inc  = beat + 2'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // ISSUE is left once the final beat has been on the port for a cycle.
  // RESP waits for the consumer to take the response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = ISSUE;
      ISSUE:   if (beat == last) state_nxt = DRAIN;
      DRAIN:   state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: the handshake, the next beat for the bank port, and the assembled read data.
  // The write enable drops whenever no write beat is being loaded.
  // The bank address, length and data hold their last values.
  always_comb begin
    ready         = (state == IDLE);
    beat_nxt      = beat;
    port_we_nxt   = 1'b0;
    port_len_nxt  = port_len;
    port_adr_nxt  = port_adr;
    port_din_nxt  = port_din;
    resp_data_nxt = 32'h0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          beat_nxt     = 2'd0;
          port_we_nxt  = bus.req_we;
          port_adr_nxt = bus.req_adr;
          if (split_now) begin
            port_len_nxt = 2'd0;
            port_din_nxt = {24'h000000, bus.req_din[7:0]};
          end else begin
            port_len_nxt = bus.req_len;
            port_din_nxt = bus.req_din;
          end
        end
      end
      ISSUE: begin
        if (beat != last) begin
          beat_nxt     = beat_inc;
          port_we_nxt  = cap_we;
          port_len_nxt = 2'd0;
          port_adr_nxt = cap_adr + {{(XMEM_AW-2){1'b0}}, beat_inc};
          port_din_nxt = {24'h000000, byte_of(cap_din, beat_inc)};
        end
      end
      DRAIN: begin
        if (cap_we) begin
          resp_data_nxt = 32'h0;
        end else if (split) begin
          if (last == 2'd1) begin
            resp_data_nxt = {16'h0000, bus.bank_dout[7:0], rbuf[0]};
          end else begin
            resp_data_nxt = {bus.bank_dout[7:0], rbuf[2], rbuf[1], rbuf[0]};
          end
        end else begin
          resp_data_nxt = mask_read(cap_len, bus.bank_dout);
        end
      end
      default: ;
    endcase
  end

  // Control and output registers: beat counter, split decision, bank port and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat       <= 2'd0;
      last       <= 2'd0;
      split      <= 1'b0;
      port_we    <= 1'b0;
      port_len   <= 2'd0;
      port_adr   <= '0;
      port_din   <= 32'h0;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
    end else begin
      beat     <= beat_nxt;
      port_we  <= port_we_nxt;
      port_len <= port_len_nxt;
      port_adr <= port_adr_nxt;
      port_din <= port_din_nxt;
      if (accept) begin
        split <= split_now;
        last  <= split_now ? last_beat_of(bus.req_len) : 2'd0;
      end
      if (state == DRAIN) begin
        resp_valid <= 1'b1;
        resp_data  <= resp_data_nxt;
      end else if ((state == RESP) && bus.rsp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // Data capture: latch the request on accept.
  // Collect the read byte of beat k two edges after that beat is loaded.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we  <= bus.req_we;
      cap_len <= bus.req_len;
      cap_adr <= bus.req_adr;
      cap_din <= bus.req_din;
    end
    if (state == ISSUE) begin
      case (beat)
        2'd1:    rbuf[0] <= bus.bank_dout[7:0];
        2'd2:    rbuf[1] <= bus.bank_dout[7:0];
        2'd3:    rbuf[2] <= bus.bank_dout[7:0];
        default: ;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = resp_valid;
  assign bus.rsp_rdata = resp_data;
  assign bus.bank_we   = port_we;
  assign bus.bank_len  = port_len;
  assign bus.bank_adr  = port_adr;
  assign bus.bank_din  = port_din;

endmodule
